// File: rtl/mem_bridge_if.sv
// External memory bus between mem_bridge (master) and the memory system (slave).
//
// Handshake: the master raises bus_req_valid with write/address/select/data and
// holds them stable until the cycle where bus_req_ready is also high. The request
// is accepted at the rising edge that ends that cycle. Writes get no response.
// A read is answered later by a one-cycle bus_resp_valid pulse with bus_resp_data.
interface mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic                    bus_req_write;
  logic [ADDR_WIDTH-1:0]   bus_req_address;
  logic [DATA_WIDTH/8-1:0] bus_req_select;
  logic [DATA_WIDTH-1:0]   bus_req_data;
  logic                    bus_resp_valid;
  logic [DATA_WIDTH-1:0]   bus_resp_data;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_address, bus_req_select, bus_req_data,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_address, bus_req_select, bus_req_data,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );
endinterface

// File: rtl/mem_bridge.sv
// Bridge from the cpu MEM-stage data port to a valid/ready memory bus.
// Stores are posted into a circular write buffer; loads stall the pipeline
// until read data returns. The buffer is fully drained before a read issues,
// so a load can never overtake an earlier store.
module mem_bridge #(
  parameter int WB_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ram_read_enable,
  input  logic [ADDR_WIDTH-1:0]           ram_read_address,
  output logic [DATA_WIDTH-1:0]           ram_read_data,
  input  logic                            ram_write_enable,
  input  logic [ADDR_WIDTH-1:0]           ram_write_address,
  input  logic [DATA_WIDTH/8-1:0]         ram_write_select,
  input  logic [DATA_WIDTH-1:0]           ram_write_data,
  output logic                            stall_request,
  output logic [$clog2(WB_DEPTH):0]       wb_count,
  output logic [1:0]                      dbg_state_o,
  mem_bridge_if.master                    bus
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic [ADDR_WIDTH-1:0]   wb_addr_q [WB_DEPTH];
  logic [SW-1:0]           wb_sel_q  [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   wb_data_q [WB_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic wb_empty;
  logic wb_full;
  logic wr_req;
  logic rd_req;
  logic push;
  logic pop;

  // A simultaneous read and write is illegal; the write wins and the read is dropped.
  assign wr_req   = ram_write_enable;
  assign rd_req   = ram_read_enable && !ram_write_enable;
  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == CW'(WB_DEPTH));

  // Head entry is offered only in IDLE; it leaves the buffer on the handshake.
  assign pop  = (state_q == IDLE) && !wb_empty && bus.bus_req_ready;
  // A full buffer still takes a store in the same cycle it frees a slot.
  assign push = wr_req && (!wb_full || pop);

  // Stores stall only on a full buffer; loads stall until the RD_DONE cycle.
  assign stall_request = (wr_req && wb_full && !pop) || (rd_req && (state_q != RD_DONE));

  assign ram_read_data = rd_data_q;
  assign wb_count      = count_q;
  assign dbg_state_o   = state_q;

  // Bus request fields: buffered write in IDLE, latched read in RD_REQ, zero otherwise.
  always_comb begin
    bus.bus_req_valid   = 1'b0;
    bus.bus_req_write   = 1'b0;
    bus.bus_req_address = '0;
    bus.bus_req_select  = '0;
    bus.bus_req_data    = '0;
    if (state_q == IDLE && !wb_empty) begin
      bus.bus_req_valid   = 1'b1;
      bus.bus_req_write   = 1'b1;
      bus.bus_req_address = wb_addr_q[rd_ptr_q];
      bus.bus_req_select  = wb_sel_q[rd_ptr_q];
      bus.bus_req_data    = wb_data_q[rd_ptr_q];
    end else if (state_q == RD_REQ) begin
      bus.bus_req_valid   = 1'b1;
      bus.bus_req_address = rd_addr_q;
      bus.bus_req_select  = '1;
    end
  end

  // Write-buffer pointer and occupancy next state; pointers wrap on power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Write-buffer storage and pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_sel_q[i]  <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        wb_addr_q[wr_ptr_q] <= ram_write_address;
        wb_sel_q[wr_ptr_q]  <= ram_write_select;
        wb_data_q[wr_ptr_q] <= ram_write_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Read FSM: one bus read outstanding, started only once the buffer is empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_empty && rd_req) begin
            state_q   <= RD_REQ;
            rd_addr_q <= ram_read_address;
          end
        end
        RD_REQ: begin
          if (bus.bus_req_ready) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.bus_resp_valid) begin
            rd_data_q <= bus.bus_resp_data;
            state_q   <= RD_DONE;
          end
        end
        RD_DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
